fmul_pipe: RTL and testbench

Parametrised, pipelined floating-point multiplier for the arithmetic verification platform. It generalises the fixed 32-bit multiplier to any binary format set by `EXP_W`/`MAN_W`. It adds a valid/ready handshake with full backpressure, four rounding modes, four operation codes and IEEE exception flags. It sits between the stimulus driver (or the DPI reference comparator) and the result scoreboard.

---
 rtl/fmul_pkg.sv | 52 +++++
 rtl/fmul_round.sv | 79 +++++++
 rtl/fmul_pipe.sv | 163 ++++++++++++++++
 tb/tb_fmul_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared types and format constants for the parametrised FP multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fmul_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_e;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_NMUL = 2'b01,
        OP_SQR  = 2'b10,
        OP_AMUL = 2'b11
    } fop_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

    typedef enum logic [1:0] {
        FC_ZERO = 2'b00,
        FC_NORM = 2'b01,
        FC_INF  = 2'b10,
        FC_NAN  = 2'b11
    } fclass_e;

    // Canonical quiet NaN: sign 0, exponent all-ones, only mantissa MSB set.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Largest finite magnitude (sign bit excluded).
    function automatic logic [63:0] max_finite_bits(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
    endfunction

    // Zero exponent means zero here: subnormals are flushed on entry.
    function automatic fclass_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic man_nz);
        if (exp_ones) return man_nz ? FC_NAN : FC_INF;
        if (exp_zero) return FC_ZERO;
        return FC_NORM;
    endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalise, round and pack the raw mantissa product of a finite non-zero multiply.
// Latency: combinational.
// Backpressure: none; values are consumed by the output stage register.
// Ports: prod (hidden-bit product), exp_in (unnormalised biased exponent, two's
// complement), sign, rmode -> result (packed word), flags {inv, ovf, unf, inx}.
module fmul_round
    import fmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]   prod,
    input  logic [EXP_W+1:0]     exp_in,
    input  logic                 sign,
    input  logic [1:0]           rmode,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int PW = 2*MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [63:0]   MAXF64   = max_finite_bits(EXP_W, MAN_W);
    localparam logic [XW-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};

    logic [PW-2:0]    norm;
    logic [MAN_W-1:0] mant;
    logic [MAN_W-1:0] mant_rnd;
    logic             g, r, s, inc, carry;
    logic [XW-1:0]    adj;
    logic [XW-1:0]    e;
    fflags_t          f;

    always_comb begin
        // Product of two [1,2) values lies in [1,4): at most one left shift.
        // The leading one is implicit and dropped from norm.
        norm = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        mant = norm[PW-2 -: MAN_W];
        g    = norm[PW-2-MAN_W];
        r    = norm[PW-3-MAN_W];
        s    = |norm[PW-4-MAN_W:0];

        case (rmode_e'(rmode))
            RM_RNE:  inc = g & (r | s | mant[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | r | s);
            default: inc = sign & (g | r | s);
        endcase

        // Mantissa wrap to zero on carry is exactly 1.0 with exponent + 1.
        {carry, mant_rnd} = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        adj = {{EXP_W{1'b0}}, {1'b0, prod[PW-1]} + {1'b0, carry}};
        e   = exp_in + adj;

        f         = '0;
        f.inexact = g | r | s;
        result    = {sign, e[EXP_W-1:0], mant_rnd};

        if (!e[XW-1] && (e >= EXP_ONES)) begin
            f.overflow = 1'b1;
            f.inexact  = 1'b1;
            case (rmode_e'(rmode))
                RM_RNE:  result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                RM_RTZ:  result = {sign, MAXF64[EXP_W+MAN_W-1:0]};
                RM_RUP:  result = sign ? {sign, MAXF64[EXP_W+MAN_W-1:0]}
                                       : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                default: result = sign ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                       : {sign, MAXF64[EXP_W+MAN_W-1:0]};
            endcase
        end else if (e[XW-1] || (e == '0)) begin
            // Would be subnormal or smaller: flush to signed zero.
            f.underflow = 1'b1;
            f.inexact   = 1'b1;
            result      = {sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    assign flags = f;

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined parametrised FP multiplier (MUL/NMUL/SQR/AMUL, four rounding modes, flags).
// Latency: 3 cycles accept-to-out_valid; 1 beat/cycle throughput.
// Backpressure: stage-wise valid with combinational ready chain from out_ready; output held while stalled.
// Ports: clk, rst_n (async low); in_valid/in_ready with op1, op2, opc, r_mode;
// out_valid/out_ready with result and flags {invalid, overflow, underflow, inexact}.
module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] op1,
    input  logic [EXP_W+MAN_W:0] op2,
    input  logic [1:0]           opc,
    input  logic [1:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam logic [XW-1:0] BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [63:0]   QNAN64 = qnan_bits(EXP_W, MAN_W);

    // Stage 1 combinational: unpack, classify, sign, exponent, special result.
    logic [W-1:0]  a, b;
    fclass_e       ca, cb;
    logic          sgn;
    logic [XW-1:0] exp_sum;
    logic          spc, spc_inv;
    logic [W-1:0]  spc_res;

    always_comb begin
        a  = op1;
        b  = (fop_e'(opc) == OP_SQR) ? op1 : op2;
        ca = classify(&a[W-2:MAN_W], ~|a[W-2:MAN_W], |a[MAN_W-1:0]);
        cb = classify(&b[W-2:MAN_W], ~|b[W-2:MAN_W], |b[MAN_W-1:0]);

        case (fop_e'(opc))
            OP_NMUL: sgn = ~(a[W-1] ^ b[W-1]);
            OP_AMUL: sgn = 1'b0;
            default: sgn = a[W-1] ^ b[W-1];
        endcase

        exp_sum = {2'b00, a[W-2:MAN_W]} + {2'b00, b[W-2:MAN_W]} - BIAS;

        spc     = 1'b1;
        spc_inv = 1'b0;
        spc_res = '0;
        if ((ca == FC_NAN) || (cb == FC_NAN) ||
            ((ca == FC_INF) && (cb == FC_ZERO)) || ((ca == FC_ZERO) && (cb == FC_INF))) begin
            spc_inv = 1'b1;
            spc_res = QNAN64[W-1:0];
        end else if ((ca == FC_INF) || (cb == FC_INF)) begin
            spc_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((ca == FC_ZERO) || (cb == FC_ZERO)) begin
            spc_res = {sgn, {(W-1){1'b0}}};
        end else begin
            spc = 1'b0;
        end
    end

    // Pipeline registers.
    logic          v1, s1_sgn, s1_spc, s1_inv;
    logic [XW-1:0] s1_exp;
    logic [MW-1:0] s1_ma, s1_mb;
    logic [1:0]    s1_rm;
    logic [W-1:0]  s1_spc_res;

    logic            v2, s2_sgn, s2_spc, s2_inv;
    logic [XW-1:0]   s2_exp;
    logic [2*MW-1:0] s2_prod;
    logic [1:0]      s2_rm;
    logic [W-1:0]    s2_spc_res;

    logic [W-1:0] rnd_res;
    logic [3:0]   rnd_flags;

    // A stage loads when empty or when its current content moves downstream.
    logic ld1, ld2, ld3;
    assign ld3      = ~out_valid | out_ready;
    assign ld2      = ~v2 | ld3;
    assign ld1      = ~v1 | ld2;
    assign in_ready = ld1;

    fmul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod   (s2_prod),
        .exp_in (s2_exp),
        .sign   (s2_sgn),
        .rmode  (s2_rm),
        .result (rnd_res),
        .flags  (rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sgn     <= 1'b0;
            s1_spc     <= 1'b0;
            s1_inv     <= 1'b0;
            s1_exp     <= '0;
            s1_ma      <= '0;
            s1_mb      <= '0;
            s1_rm      <= '0;
            s1_spc_res <= '0;
            v2         <= 1'b0;
            s2_sgn     <= 1'b0;
            s2_spc     <= 1'b0;
            s2_inv     <= 1'b0;
            s2_exp     <= '0;
            s2_prod    <= '0;
            s2_rm      <= '0;
            s2_spc_res <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            flags      <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sgn     <= sgn;
                    s1_spc     <= spc;
                    s1_inv     <= spc_inv;
                    s1_exp     <= exp_sum;
                    s1_ma      <= {1'b1, a[MAN_W-1:0]};
                    s1_mb      <= {1'b1, b[MAN_W-1:0]};
                    s1_rm      <= r_mode;
                    s1_spc_res <= spc_res;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sgn     <= s1_sgn;
                    s2_spc     <= s1_spc;
                    s2_inv     <= s1_inv;
                    s2_exp     <= s1_exp;
                    s2_prod    <= {{MW{1'b0}}, s1_ma} * {{MW{1'b0}}, s1_mb};
                    s2_rm      <= s1_rm;
                    s2_spc_res <= s1_spc_res;
                end
            end
            if (ld3) begin
                out_valid <= v2;
                if (v2) begin
                    result <= s2_spc ? s2_spc_res : rnd_res;
                    flags  <= s2_spc ? {s2_inv, 3'b000} : rnd_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op1, op2, result;
    logic [1:0]  opc, r_mode;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_op1, h_op2, h_result;
    logic [1:0]  h_opc, h_r_mode;
    logic [3:0]  h_flags;

    always #5 clk = ~clk;

    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opc(opc), .r_mode(r_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fmul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op1(h_op1), .op2(h_op2), .opc(h_opc), .r_mode(h_r_mode),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    int          ncomp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          n_pop = 0;
    int          last_lat = -1;
    logic [35:0] exp_q[$];
    int          acc_q[$];
    logic [35:0] pend_exp;
    logic        acc;
    logic        held_vld = 1'b0;
    logic [31:0] held_res;
    logic [3:0]  held_flg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference FP32 multiply: exact integer product, rounding by remainder comparison.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] bi,
                                          input logic [1:0] oc, input logic [1:0] rm);
        logic [31:0]     b;
        logic            s, up, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int              ea, eb, k, sh, ex;
        longint unsigned p, kept, rem, half;
        logic [30:0]     inf_m, max_m, mag;
        b      = (oc == 2'd2) ? a : bi;
        s      = (oc == 2'd3) ? 1'b0 : (a[31] ^ b[31] ^ (oc == 2'd1));
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        inf_m  = {8'hFF, 23'd0};
        max_m  = {8'hFE, 23'h7FFFFF};
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, inf_m};
        if (a_zero || b_zero) return {4'b0000, s, 31'd0};
        p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        k = 63;
        while (p[k] == 1'b0) k--;
        sh   = k - 23;
        kept = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        ex   = ea + eb - 127 + (k - 46);
        case (rm)
            2'd0:    up = (rem > half) || ((rem == half) && kept[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = !s && (rem != 0);
            default: up = s && (rem != 0);
        endcase
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            ex++;
        end
        if (ex >= 255) begin
            case (rm)
                2'd0:    mag = inf_m;
                2'd1:    mag = max_m;
                2'd2:    mag = s ? max_m : inf_m;
                default: mag = s ? inf_m : max_m;
            endcase
            return {4'b0101, s, mag};
        end
        if (ex <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, (rem != 0), s, 8'(ex), kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] m;
        k = int'($urandom_range(0, 9));
        m = 23'($urandom);
        case (k)
            0: begin
                e = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                if ($urandom_range(0, 1) != 0) m = '0;
            end
            1:       e = 8'($urandom_range(190, 254));
            2:       e = 8'($urandom_range(1, 70));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, m};
    endfunction

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic step();
        logic [35:0] e;
        @(negedge clk);
        cyc++;
        if (held_vld) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(held_res));
            check("hold_flags", 64'(flags), 64'(held_flg));
        end
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            ncomp++;
            assert (exp_q.size() != 0) else begin
                nfail++;
                $error("FAIL unexpected_output: got %h with nothing expected", result);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                last_lat = cyc - acc_q.pop_front();
                n_pop++;
                check("sb_result", 64'(result), 64'(e[31:0]));
                check("sb_flags", 64'(flags), 64'(e[35:32]));
            end
        end
        if (acc) begin
            exp_q.push_back(pend_exp);
            acc_q.push_back(cyc);
        end
        held_vld = out_valid && !out_ready;
        held_res = result;
        held_flg = flags;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] oc,
                        input logic [1:0] rm, input logic [35:0] exp);
        bit ok = 0;
        op1 = a; op2 = b; opc = oc; r_mode = rm; pend_exp = exp; in_valid = 1'b1;
        repeat (50) begin
            step();
            if (acc) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        ncomp++;
        assert (ok) else begin
            nfail++;
            $error("FAIL send_timeout: got no accept expected accept for %h x %h", a, b);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (200) begin
            if (exp_q.size() == 0) break;
            step();
        end
        ncomp++;
        assert (exp_q.size() == 0) else begin
            nfail++;
            $error("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        int sent, guard, pops_before;
        bit hv;
        in_valid = 0; op1 = 0; op2 = 0; opc = 0; r_mode = 0; out_ready = 1;
        h_in_valid = 0; h_op1 = 0; h_op2 = 0; h_opc = 0; h_r_mode = 0; h_out_ready = 1;
        pend_exp = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // First directed case alone to measure latency.
        send(32'h3FC00000, 32'h40000000, 2'd0, 2'd0, {4'b0000, 32'h40400000});
        drain();
        check("latency", 64'(last_lat), 64'd3);

        // Directed cases back to back.
        send(32'h3F800001, 32'h3F800001, 2'd0, 2'd0, {4'b0001, 32'h3F800002});
        send(32'h3F800001, 32'h3F800001, 2'd0, 2'd2, {4'b0001, 32'h3F800003});
        send(32'h3F800001, 32'h3F800001, 2'd0, 2'd1, {4'b0001, 32'h3F800002});
        send(32'h7F7FFFFF, 32'h40000000, 2'd0, 2'd0, {4'b0101, 32'h7F800000});
        send(32'h7F7FFFFF, 32'h40000000, 2'd0, 2'd1, {4'b0101, 32'h7F7FFFFF});
        send(32'h7F7FFFFF, 32'h40000000, 2'd1, 2'd2, {4'b0101, 32'hFF7FFFFF});
        send(32'h7F7FFFFF, 32'h40000000, 2'd0, 2'd3, {4'b0101, 32'h7F7FFFFF});
        send(32'h7F800000, 32'h00000000, 2'd0, 2'd0, {4'b1000, 32'h7FC00000});
        send(32'h00800000, 32'h3F000000, 2'd0, 2'd0, {4'b0011, 32'h00000000});
        send(32'hC0000000, 32'h12345678, 2'd2, 2'd0, {4'b0000, 32'h40800000});
        send(32'hC0000000, 32'h40400000, 2'd3, 2'd0, {4'b0000, 32'h40C00000});
        send(32'h3FC00000, 32'h40000000, 2'd1, 2'd0, {4'b0000, 32'hC0400000});
        send(32'h00400000, 32'h3F800000, 2'd0, 2'd0, {4'b0000, 32'h00000000});
        send(32'h7FC00001, 32'h3F800000, 2'd0, 2'd0, {4'b1000, 32'h7FC00000});
        send(32'hFF800000, 32'h40000000, 2'd0, 2'd0, {4'b0000, 32'hFF800000});
        drain();

        // Random beats under pseudo-random backpressure, checked against the model.
        sent = 0;
        guard = 0;
        while (((sent < 20) || (exp_q.size() != 0)) && (guard < 2000)) begin
            if (!in_valid && (sent < 20) && ($urandom_range(0, 3) != 0)) begin
                op1      = rand_op();
                op2      = rand_op();
                opc      = 2'($urandom_range(0, 3));
                r_mode   = 2'($urandom_range(0, 3));
                pend_exp = model(op1, op2, opc, r_mode);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            guard++;
        end
        ncomp++;
        assert ((sent == 20) && (exp_q.size() == 0)) else begin
            nfail++;
            $error("FAIL random_stream: got %0d sent %0d pending expected 20 sent 0 pending",
                   sent, exp_q.size());
        end

        // Fill all three stages while stalled, then reset.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 2'd0, 2'd0, {4'b0000, 32'h3F800000});
        send(32'h40000000, 32'h40000000, 2'd0, 2'd0, {4'b0000, 32'h40800000});
        send(32'h40400000, 32'h40000000, 2'd0, 2'd0, {4'b0000, 32'h40C00000});
        check("inflight_valid", 64'(out_valid), 64'd1);
        check("inflight_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        exp_q.delete();
        acc_q.delete();
        held_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        pops_before = n_pop;
        repeat (8) step();
        check("no_stale_beats", 64'(n_pop), 64'(pops_before));

        // Pipeline still works after the mid-flight reset.
        send(32'h3FC00000, 32'h40000000, 2'd0, 2'd0, {4'b0000, 32'h40400000});
        drain();
        check("latency_after_rst", 64'(last_lat), 64'd3);

        // Half-precision instance.
        h_op1 = 16'h3E00; h_op2 = 16'h4000; h_opc = 2'd0; h_r_mode = 2'd0; h_in_valid = 1'b1;
        @(negedge clk);
        check("h_in_ready", 64'(h_in_ready), 64'd1);
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        hv = 0;
        repeat (20) begin
            @(negedge clk);
            if (h_out_valid) begin hv = 1; break; end
        end
        check("h_out_valid", 64'(hv), 64'd1);
        check("h_result", 64'(h_result), 64'h4200);
        check("h_flags", 64'(h_flags), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
